// File: rtl/axi_sram_ctrl.sv
// AXI4 slave to single-port SRAM bridge.
// One beat at a time. Reads take two cycles per beat: request, then data.
// Writes take one cycle per beat; each W handshake goes straight to the SRAM.
module axi_sram_ctrl #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int AXI_USER_WIDTH = 1,
    parameter int MEM_ADDR_WIDTH = 13
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        test_en_i,
    // write address channel
    input  logic                        aw_valid,
    output logic                        aw_ready,
    input  logic [AXI_ID_WIDTH-1:0]     aw_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr,
    input  logic [7:0]                  aw_len,
    input  logic [2:0]                  aw_size,
    input  logic [1:0]                  aw_burst,
    input  logic [AXI_USER_WIDTH-1:0]   aw_user,
    // write data channel
    input  logic                        w_valid,
    output logic                        w_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] w_strb,
    input  logic                        w_last,
    input  logic [AXI_USER_WIDTH-1:0]   w_user,
    // write response channel
    output logic                        b_valid,
    input  logic                        b_ready,
    output logic [AXI_ID_WIDTH-1:0]     b_id,
    output logic [1:0]                  b_resp,
    output logic [AXI_USER_WIDTH-1:0]   b_user,
    // read address channel
    input  logic                        ar_valid,
    output logic                        ar_ready,
    input  logic [AXI_ID_WIDTH-1:0]     ar_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr,
    input  logic [7:0]                  ar_len,
    input  logic [2:0]                  ar_size,
    input  logic [1:0]                  ar_burst,
    input  logic [AXI_USER_WIDTH-1:0]   ar_user,
    // read data channel
    output logic                        r_valid,
    input  logic                        r_ready,
    output logic [AXI_ID_WIDTH-1:0]     r_id,
    output logic [AXI_DATA_WIDTH-1:0]   r_data,
    output logic [1:0]                  r_resp,
    output logic                        r_last,
    output logic [AXI_USER_WIDTH-1:0]   r_user,
    // SRAM side
    output logic                        mem_req_o,
    output logic [MEM_ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                        mem_we_o,
    output logic [AXI_DATA_WIDTH/8-1:0] mem_be_o,
    output logic [AXI_DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [AXI_DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, R_REQ, R_DATA, W_DATA, W_RESP} state_t;

    state_t                    state;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [AXI_ADDR_WIDTH-1:0] addr_next;
    logic [AXI_ADDR_WIDTH-1:0] wrap_mask;
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [7:0]                len;
    logic [1:0]                burst;
    logic [8:0]                beat;       // beats already completed, saturating
    logic                      last_write; // 1 when the last served channel was a write
    logic                      r_first;    // first cycle of an R beat: SRAM data is live
    logic [1:0]                resp;
    logic [AXI_DATA_WIDTH-1:0] rdata_hold;
    logic                      sel_read;
    logic                      w_fire;
    logic                      beat_is_last;

    // Size is always treated as 4 bytes; user inputs and test enable have no function.
    logic unused_inputs;
    assign unused_inputs = ^{test_en_i, aw_size, ar_size, aw_user, ar_user, w_user};

    // Arbitration: a lone valid wins; when both are valid, the side not served last wins.
    assign sel_read = ar_valid && (!aw_valid || last_write);
    assign ar_ready = (state == IDLE) && sel_read;
    assign aw_ready = (state == IDLE) && aw_valid && !sel_read;

    assign w_ready      = (state == W_DATA);
    assign w_fire       = w_ready && w_valid;
    assign beat_is_last = (beat == {1'b0, len});

    assign r_valid = (state == R_DATA);
    assign r_id    = id;
    assign r_data  = r_first ? mem_rdata_i : rdata_hold;
    assign r_resp  = RESP_OKAY;
    assign r_last  = r_valid && beat_is_last;
    assign r_user  = '0;

    assign b_valid = (state == W_RESP);
    assign b_id    = id;
    assign b_resp  = resp;
    assign b_user  = '0;

    assign mem_req_o   = (state == R_REQ) || w_fire;
    assign mem_we_o    = w_fire;
    assign mem_be_o    = (state == R_REQ) ? '1 : (w_fire ? w_strb : '0);
    assign mem_wdata_o = w_fire ? w_data : '0;
    assign mem_addr_o  = addr[MEM_ADDR_WIDTH+1:2];

    // Wrap boundary is (len+1)*4 bytes; legal wrap lengths make this a low-bit mask.
    assign wrap_mask = AXI_ADDR_WIDTH'({len, 2'b11});

    // Next beat address from the latched burst type; reserved encoding behaves as INCR.
    always_comb begin
        addr_next = addr + AXI_ADDR_WIDTH'(4);
        case (burst)
            2'b00:   addr_next = addr;
            2'b10:   addr_next = (addr & ~wrap_mask) | ((addr + AXI_ADDR_WIDTH'(4)) & wrap_mask);
            default: addr_next = addr + AXI_ADDR_WIDTH'(4);
        endcase
    end

    // Transaction FSM: latches the accepted request and walks it beat by beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            id         <= '0;
            len        <= '0;
            burst      <= '0;
            beat       <= '0;
            last_write <= 1'b1;
            r_first    <= 1'b0;
            resp       <= RESP_OKAY;
            rdata_hold <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_valid && ar_ready) begin
                        id         <= ar_id;
                        addr       <= ar_addr;
                        len        <= ar_len;
                        burst      <= ar_burst;
                        beat       <= '0;
                        last_write <= 1'b0;
                        state      <= R_REQ;
                    end else if (aw_valid && aw_ready) begin
                        id         <= aw_id;
                        addr       <= aw_addr;
                        len        <= aw_len;
                        burst      <= aw_burst;
                        beat       <= '0;
                        last_write <= 1'b1;
                        state      <= W_DATA;
                    end
                end
                R_REQ: begin
                    r_first <= 1'b1;
                    state   <= R_DATA;
                end
                R_DATA: begin
                    // SRAM data is only valid for one cycle; keep it for a stalled beat.
                    if (r_first) begin
                        rdata_hold <= mem_rdata_i;
                    end
                    r_first <= 1'b0;
                    if (r_ready) begin
                        if (beat_is_last) begin
                            state <= IDLE;
                        end else begin
                            addr  <= addr_next;
                            beat  <= beat + 9'd1;
                            state <= R_REQ;
                        end
                    end
                end
                W_DATA: begin
                    if (w_valid) begin
                        addr <= addr_next;
                        if (beat != '1) begin
                            beat <= beat + 9'd1;
                        end
                        if (w_last) begin
                            resp  <= beat_is_last ? RESP_OKAY : RESP_SLVERR;
                            state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_ctrl.sv
// Bench for axi_sram_ctrl: directed scenarios followed by randomized bursts,
// with an SRAM model and a word-level reference memory kept in the bench.
module tb_axi_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        test_en_i;
    logic        aw_valid, aw_ready;
    logic [2:0]  aw_id;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic [0:0]  aw_user;
    logic        w_valid, w_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last;
    logic [0:0]  w_user;
    logic        b_valid, b_ready;
    logic [2:0]  b_id;
    logic [1:0]  b_resp;
    logic [0:0]  b_user;
    logic        ar_valid, ar_ready;
    logic [2:0]  ar_id;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic [0:0]  ar_user;
    logic        r_valid, r_ready;
    logic [2:0]  r_id;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [0:0]  r_user;
    logic        mem_req_o;
    logic [12:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem     [8192];
    logic [31:0] ref_mem [8192];
    logic [17:0] acc_q[$];   // {we, word address, byte enables} of each SRAM strobe

    axi_sram_ctrl dut (
        .clk(clk), .rst_n(rst_n), .test_en_i(test_en_i),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
        .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst), .aw_user(aw_user),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
        .w_last(w_last), .w_user(w_user),
        .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp), .b_user(b_user),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst), .ar_user(ar_user),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
        .r_resp(r_resp), .r_last(r_last), .r_user(r_user),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    // SRAM: read data valid only in the cycle after a read strobe, noise otherwise.
    always @(posedge clk) begin
        if (mem_req_o && mem_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be_o[b]) mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end
        end
        if (mem_req_o && !mem_we_o) mem_rdata_i <= mem[mem_addr_o];
        else                        mem_rdata_i <= $urandom;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mem_req_o) acc_q.push_back({mem_we_o, mem_addr_o, mem_be_o});
        if (rst_n && ar_valid && aw_valid) chk("ready_exclusive", {31'b0, ar_ready & aw_ready}, 32'd0);
    end

    function automatic logic [12:0] widx(input logic [31:0] a);
        return a[14:2];
    endfunction

    // Reference address sequence, from the burst rules in plain arithmetic.
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] bu, input int ln);
        int unsigned bytes;
        logic [31:0] base;
        if (bu == 2'b00) return a;
        if (bu == 2'b10) begin
            bytes = (ln + 1) * 4;
            base  = a - (a % bytes);
            return base + ((a - base + 4) % bytes);
        end
        return a + 32'd4;
    endfunction

    function automatic logic pick(input int sel);
        case (sel)
            0:       return ar_ready;
            1:       return aw_ready;
            2:       return r_valid;
            default: return b_valid;
        endcase
    endfunction

    task automatic tick_n();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_for(input string tag, input int sel, output int cyc);
        cyc = 1;
        tick_n();
        while (!pick(sel) && cyc < 64) begin
            tick_n();
            cyc++;
        end
        chk(tag, {31'b0, pick(sel)}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ar_ready"}, {31'b0, ar_ready}, 0);
        chk({tag, "_aw_ready"}, {31'b0, aw_ready}, 0);
        chk({tag, "_w_ready"},  {31'b0, w_ready}, 0);
        chk({tag, "_r_valid"},  {31'b0, r_valid}, 0);
        chk({tag, "_b_valid"},  {31'b0, b_valid}, 0);
        chk({tag, "_mem_req"},  {31'b0, mem_req_o}, 0);
        chk({tag, "_mem_we"},   {31'b0, mem_we_o}, 0);
        chk({tag, "_mem_be"},   {28'b0, mem_be_o}, 0);
        chk({tag, "_mem_addr"}, {19'b0, mem_addr_o}, 0);
        chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
    endtask

    task automatic ar_drive(input int id, input logic [31:0] a, input int ln, input logic [1:0] bu);
        ar_valid = 1'b1; ar_id = 3'(id); ar_addr = a; ar_len = 8'(ln); ar_burst = bu;
        ar_size = 3'($urandom_range(0, 7));
    endtask

    task automatic aw_drive(input int id, input logic [31:0] a, input int ln, input logic [1:0] bu);
        aw_valid = 1'b1; aw_id = 3'(id); aw_addr = a; aw_len = 8'(ln); aw_burst = bu;
        aw_size = 3'($urandom_range(0, 7));
    endtask

    // Accept len+1 R beats, optionally stalling one of them.
    task automatic read_beats(input int id, input logic [31:0] addr, input int ln, input logic [1:0] bu,
                              input int stall_beat, input int stall_cyc);
        logic [31:0] a;
        int cyc;
        a = addr;
        for (int i = 0; i <= ln; i++) begin
            wait_for("r_valid_seen", 2, cyc);
            chk("r_beat_latency", cyc, 2);
            chk("rd_req_count", acc_q.size(), 1);
            if (acc_q.size() > 0) chk("rd_req_addr", {14'b0, acc_q[0]}, {14'b0, 1'b0, widx(a), 4'hF});
            if (i == stall_beat) begin
                for (int s = 0; s < stall_cyc; s++) begin
                    tick_n();
                    chk("stall_r_valid", {31'b0, r_valid}, 1);
                    chk("stall_r_data", r_data, ref_mem[widx(a)]);
                    chk("stall_no_req", acc_q.size(), 1);
                end
            end
            chk("r_data", r_data, ref_mem[widx(a)]);
            chk("r_id", {29'b0, r_id}, 32'(id[2:0]));
            chk("r_resp", {30'b0, r_resp}, 0);
            chk("r_last", {31'b0, r_last}, {31'b0, i == ln});
            r_ready = 1'b1;
            @(posedge clk);
            #1 r_ready = 1'b0;
            if (acc_q.size() > 0) void'(acc_q.pop_front());
            a = next_addr(a, bu, ln);
        end
    endtask

    task automatic axi_read(input int id, input logic [31:0] a, input int ln, input logic [1:0] bu,
                            input int stall_beat, input int stall_cyc);
        int cyc;
        ar_drive(id, a, ln, bu);
        wait_for("ar_ready_seen", 0, cyc);
        @(posedge clk);
        #1 ar_valid = 1'b0;
        read_beats(id, a, ln, bu, stall_beat, stall_cyc);
    endtask

    // Drive nbeats back-to-back W beats (w_last on the final one) and take the response.
    task automatic write_beats(input int id, input logic [31:0] addr, input int ln, input logic [1:0] bu,
                               input int nbeats, input bit full_strb);
        logic [31:0] a;
        int cyc;
        a = addr;
        for (int i = 0; i < nbeats; i++) begin
            w_valid = 1'b1;
            w_data  = $urandom;
            w_strb  = full_strb ? 4'hF : 4'($urandom_range(0, 15));
            w_last  = (i == nbeats - 1);
            tick_n();
            chk("w_ready", {31'b0, w_ready}, 1);
            chk("wr_req", {31'b0, mem_req_o}, 1);
            chk("wr_we", {31'b0, mem_we_o}, 1);
            chk("wr_addr", {19'b0, mem_addr_o}, {19'b0, widx(a)});
            chk("wr_be", {28'b0, mem_be_o}, {28'b0, w_strb});
            chk("wr_data", mem_wdata_o, w_data);
            for (int b = 0; b < 4; b++) begin
                if (w_strb[b]) ref_mem[widx(a)][8*b +: 8] = w_data[8*b +: 8];
            end
            @(posedge clk);
            #1;
            a = next_addr(a, bu, ln);
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
        acc_q.delete();
        b_ready = 1'b1;
        wait_for("b_valid_seen", 3, cyc);
        chk("b_latency", cyc, 1);
        chk("b_no_req", {31'b0, mem_req_o}, 0);
        chk("b_resp", {30'b0, b_resp}, (nbeats == ln + 1) ? 32'd0 : 32'd2);
        chk("b_id", {29'b0, b_id}, 32'(id[2:0]));
        @(posedge clk);
        #1 b_ready = 1'b0;
    endtask

    task automatic axi_write(input int id, input logic [31:0] a, input int ln, input logic [1:0] bu,
                             input int nbeats, input bit full_strb);
        int cyc;
        aw_drive(id, a, ln, bu);
        w_valid = 1'b1; w_data = 32'hA5A5_5A5A; w_strb = 4'hF; w_last = 1'b0;
        wait_for("aw_ready_seen", 1, cyc);
        chk("w_stall_in_idle", {31'b0, w_ready}, 0);
        chk("w_idle_no_req", {31'b0, mem_req_o}, 0);
        @(posedge clk);
        #1 aw_valid = 1'b0;
        write_beats(id, a, ln, bu, nbeats, full_strb);
    endtask

    initial begin
        int cyc;
        logic [1:0]  bu;
        int          ln;
        int          nb;
        logic [31:0] ad;

        rst_n = 1'b0; test_en_i = 1'b0;
        aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0; aw_user = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; w_user = 0; b_ready = 0;
        ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0; ar_user = 0;
        r_ready = 0;
        for (int i = 0; i < 8192; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;

        #3 chk_reset_outputs("reset0");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // single-beat read of word 4
        axi_read(5, 32'h2000_0010, 0, 2'b01, -1, 0);
        // 4-beat INCR write to words 2..5, then read them back
        axi_write(0, 32'h8, 3, 2'b01, 4, 1'b1);
        axi_read(1, 32'h8, 3, 2'b01, -1, 0);
        // WRAP read 3,0,1,2 with a 3-cycle stall on the third beat
        axi_read(1, 32'hC, 3, 2'b10, 2, 3);
        // early w_last: 2 of 4 beats, SLVERR, then a normal read
        axi_write(2, 32'h40, 3, 2'b01, 2, 1'b0);
        axi_read(2, 32'h40, 3, 2'b01, -1, 0);
        // extra beat past len+1 still written, SLVERR
        axi_write(3, 32'h80, 0, 2'b01, 2, 1'b0);
        axi_read(3, 32'h80, 1, 2'b01, 0, 1);
        // FIXED and reserved bursts, INCR wrap across the top of the address space
        axi_write(4, 32'h100, 2, 2'b00, 3, 1'b0);
        axi_read(4, 32'h100, 2, 2'b00, 1, 2);
        axi_write(6, 32'h200, 2, 2'b11, 3, 1'b1);
        axi_read(6, 32'hFFFF_FFF8, 3, 2'b01, -1, 0);
        axi_read(7, 32'h200, 2, 2'b11, -1, 0);

        // reset during beat 2 of a len=7 read
        ar_drive(6, 32'h100, 7, 2'b01);
        wait_for("ar_ready_seen", 0, cyc);
        @(posedge clk);
        #1 ar_valid = 1'b0;
        r_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_for("r_valid_seen", 2, cyc);
            @(posedge clk);
            #1;
        end
        wait_for("r_valid_seen", 2, cyc);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("reset_mid");
        r_ready = 1'b0;
        acc_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // simultaneous AR/AW: read, write, read, write
        ar_drive(1, 32'h2000_0010, 0, 2'b01);
        aw_drive(2, 32'h300, 0, 2'b01);
        tick_n();
        chk("arb1_ar", {31'b0, ar_ready}, 1);
        chk("arb1_aw", {31'b0, aw_ready}, 0);
        @(posedge clk);
        #1 ar_valid = 1'b0;
        read_beats(1, 32'h2000_0010, 0, 2'b01, -1, 0);
        ar_drive(3, 32'h300, 0, 2'b01);
        tick_n();
        chk("arb2_aw", {31'b0, aw_ready}, 1);
        chk("arb2_ar", {31'b0, ar_ready}, 0);
        @(posedge clk);
        #1 aw_valid = 1'b0;
        write_beats(2, 32'h300, 0, 2'b01, 1, 1'b0);
        aw_drive(4, 32'h304, 0, 2'b01);
        tick_n();
        chk("arb3_ar", {31'b0, ar_ready}, 1);
        chk("arb3_aw", {31'b0, aw_ready}, 0);
        @(posedge clk);
        #1 ar_valid = 1'b0;
        read_beats(3, 32'h300, 0, 2'b01, -1, 0);
        tick_n();
        chk("arb4_aw", {31'b0, aw_ready}, 1);
        @(posedge clk);
        #1 aw_valid = 1'b0;
        write_beats(4, 32'h304, 0, 2'b01, 1, 1'b0);

        // randomized bursts
        for (int t = 0; t < 40; t++) begin
            bu = 2'($urandom_range(0, 3));
            ln = (bu == 2'b10) ? ((2 << $urandom_range(0, 3)) - 1) : int'($urandom_range(0, 7));
            ad = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 1) begin
                nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, ln + 2)) : ln + 1;
                axi_write(t, ad, ln, bu, nb, 1'b0);
                axi_read(t + 1, ad, ln, bu, int'($urandom_range(0, ln)), int'($urandom_range(0, 3)));
            end else begin
                axi_read(t, ad, ln, bu, int'($urandom_range(0, ln)), int'($urandom_range(0, 3)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
